// File: rtl/ppu_frame_writer.sv
// ppu_frame_writer: packs 2-bit PPU pixels four per byte, queues them and
// writes them into a 160x144 framebuffer through a waitrequest write port.
// Ports: clk, rst (async, active-low); LCD_EN, PPU_MODE, PX_IN, PX_valid,
//   BGP from the PPU; FB_ADDR, FB_WRDATA, FB_WR, FB_WAITREQ write port;
//   FRAME_DONE one-cycle pulse; OVERFLOW sticky FIFO-drop flag.
// Option: define PPU_FRAME_WRITER_PALETTE_EN to map pixels through BGP.
module ppu_frame_writer #(
  parameter int          FIFO_DEPTH = 8,
  parameter int          LINE_PX    = 160,
  parameter int          LINES      = 144,
  parameter logic [12:0] FB_BASE    = 13'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        LCD_EN,
  input  logic [1:0]  PPU_MODE,
  input  logic [1:0]  PX_IN,
  input  logic        PX_valid,
  input  logic [7:0]  BGP,
  output logic [12:0] FB_ADDR,
  output logic [7:0]  FB_WRDATA,
  output logic        FB_WR,
  input  logic        FB_WAITREQ,
  output logic        FRAME_DONE,
  output logic        OVERFLOW
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] PTR_ONE = {{PW{1'b0}}, 1'b1};
  localparam logic [7:0] LINE_PX_W = 8'(LINE_PX);
  localparam logic [7:0] LINES_W = 8'(LINES);

  localparam logic [1:0] M_HBLANK = 2'd0;
  localparam logic [1:0] M_VBLANK = 2'd1;
  localparam logic [1:0] M_DRAW   = 2'd3;

  typedef enum logic {
    S_IDLE,
    S_WRITE
  } state_t;

  // Pixel front end
  logic [1:0]  prev_mode_q, prev_mode_d;
  logic [7:0]  x_q, x_d;
  logic [7:0]  y_q, y_d;
  logic [1:0]  phase_q, phase_d;
  logic [5:0]  pack_q, pack_d;
  logic        wvld_q, wvld_d;
  logic [12:0] waddr_q, waddr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        done_pend_q, done_pend_d;
  logic        ovf_q, ovf_d;

  // FIFO
  logic [20:0] mem_q [FIFO_DEPTH];
  logic [PW:0] wr_ptr_q, wr_ptr_d;
  logic [PW:0] rd_ptr_q, rd_ptr_d;

  // Write port
  state_t      state_q, state_d;
  logic [12:0] fb_addr_q, fb_addr_d;
  logic [7:0]  fb_data_q, fb_data_d;
  logic        fb_wr_q, fb_wr_d;

  logic        hb_edge;
  logic        vb_edge;
  logic        accept;
  logic [1:0]  px_map;
  logic [1:0]  phase_a;
  logic [5:0]  pack_a;
  logic [12:0] y13;
  logic [12:0] row_base;
  logic [12:0] word_addr;
  logic [7:0]  partial;
  logic        empty;
  logic        full;
  logic        pop;
  logic        push_ok;
  logic        drop;
  logic        frame_done;
  logic [20:0] rd_word;

`ifdef PPU_FRAME_WRITER_PALETTE_EN
  always_comb begin
    px_map = BGP[1:0];
    unique case (PX_IN)
      2'd0: px_map = BGP[1:0];
      2'd1: px_map = BGP[3:2];
      2'd2: px_map = BGP[5:4];
      2'd3: px_map = BGP[7:6];
      default: px_map = BGP[1:0];
    endcase
  end
`else
  logic unused_bgp;
  assign unused_bgp = ^BGP;
  assign px_map = PX_IN;
`endif

  assign hb_edge = (PPU_MODE == M_HBLANK) && (prev_mode_q == M_DRAW);
  assign vb_edge = (PPU_MODE == M_VBLANK) && (prev_mode_q != M_VBLANK);

  assign accept = PX_valid && LCD_EN
               && (x_q < LINE_PX_W) && (y_q < LINES_W);

  assign phase_a = accept ? phase_q + 2'd1 : phase_q;
  assign pack_a  = accept ? {pack_q[3:0], px_map} : pack_q;

  // y*40 as (y<<5)+(y<<3), 13-bit wrap
  assign y13      = {5'b0, y_q};
  assign row_base = FB_BASE + (y13 << 5) + (y13 << 3);
  // While a word is open, x_q always lies inside it (even right after
  // the 4th-pixel accept, since x_q is the pre-increment value).
  assign word_addr = row_base + {7'b0, x_q[7:2]};

  always_comb begin
    partial = 8'h00;
    unique case (phase_a)
      2'd1: partial = {pack_a[1:0], 6'b0};
      2'd2: partial = {pack_a[3:0], 4'b0};
      2'd3: partial = {pack_a, 2'b0};
      default: partial = 8'h00;
    endcase
  end

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PW] != rd_ptr_q[PW])
              && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign rd_word = mem_q[rd_ptr_q[PW-1:0]];

  // The pack stage output is still in flight, so it blocks FRAME_DONE too.
  assign frame_done = done_pend_q && empty && !fb_wr_q && !wvld_q;

  // Pack / counter logic
  always_comb begin
    prev_mode_d = PPU_MODE;
    x_d         = accept ? x_q + 8'd1 : x_q;
    y_d         = y_q;
    phase_d     = phase_a;
    pack_d      = pack_a;
    wvld_d      = 1'b0;
    waddr_d     = waddr_q;
    wdata_d     = wdata_q;
    done_pend_d = done_pend_q;
    ovf_d       = ovf_q;

    if (accept && (phase_q == 2'd3)) begin
      wvld_d  = 1'b1;
      waddr_d = word_addr;
      wdata_d = {pack_q, px_map};
    end else if (hb_edge && (phase_a != 2'd0)) begin
      wvld_d  = 1'b1;
      waddr_d = word_addr;
      wdata_d = partial;
    end

    if (hb_edge) begin
      x_d     = 8'd0;
      phase_d = 2'd0;
      pack_d  = 6'd0;
      if (y_q < LINES_W) y_d = y_q + 8'd1;
    end

    if (frame_done) done_pend_d = 1'b0;

    if (vb_edge) begin
      x_d         = 8'd0;
      y_d         = 8'd0;
      phase_d     = 2'd0;
      pack_d      = 6'd0;
      done_pend_d = 1'b1;
      ovf_d       = 1'b0;
    end

    if (!LCD_EN) begin
      x_d         = 8'd0;
      y_d         = 8'd0;
      phase_d     = 2'd0;
      pack_d      = 6'd0;
      done_pend_d = 1'b0;
    end

    if (drop) ovf_d = 1'b1;
  end

  // A pop in the same cycle frees a slot for the push.
  assign push_ok = wvld_q && (!full || pop);
  assign drop    = wvld_q && full && !pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop) rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  // Write FSM
  always_comb begin
    state_d   = state_q;
    fb_addr_d = fb_addr_q;
    fb_data_d = fb_data_q;
    fb_wr_d   = fb_wr_q;
    pop       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          fb_addr_d = rd_word[20:8];
          fb_data_d = rd_word[7:0];
          fb_wr_d   = 1'b1;
          state_d   = S_WRITE;
        end
      end
      S_WRITE: begin
        if (!FB_WAITREQ) begin
          if (!empty) begin
            pop       = 1'b1;
            fb_addr_d = rd_word[20:8];
            fb_data_d = rd_word[7:0];
          end else begin
            fb_wr_d = 1'b0;
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        fb_wr_d = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_mode_q <= M_HBLANK;
      x_q         <= 8'd0;
      y_q         <= 8'd0;
      phase_q     <= 2'd0;
      pack_q      <= 6'd0;
      wvld_q      <= 1'b0;
      waddr_q     <= 13'd0;
      wdata_q     <= 8'd0;
      done_pend_q <= 1'b0;
      ovf_q       <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      state_q     <= S_IDLE;
      fb_addr_q   <= 13'd0;
      fb_data_q   <= 8'd0;
      fb_wr_q     <= 1'b0;
    end else begin
      prev_mode_q <= prev_mode_d;
      x_q         <= x_d;
      y_q         <= y_d;
      phase_q     <= phase_d;
      pack_q      <= pack_d;
      wvld_q      <= wvld_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      done_pend_q <= done_pend_d;
      ovf_q       <= ovf_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      state_q     <= state_d;
      fb_addr_q   <= fb_addr_d;
      fb_data_q   <= fb_data_d;
      fb_wr_q     <= fb_wr_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else if (push_ok) begin
      mem_q[wr_ptr_q[PW-1:0]] <= {waddr_q, wdata_q};
    end
  end

  assign FB_ADDR    = fb_addr_q;
  assign FB_WRDATA  = fb_data_q;
  assign FB_WR      = fb_wr_q;
  assign FRAME_DONE = frame_done;
  assign OVERFLOW   = ovf_q;

endmodule

// File: doc/ppu_frame_writer.md
Name: ppu_frame_writer

Overview:
- Consumer end of the PPU pixel stream: accepts 2-bit pixels (PX_IN/PX_valid) and PPU_MODE from the PPU.
- Optionally maps pixels through BGP, then packs 4 pixels per byte.
- Buffers packed bytes in a small FIFO and writes them to a 160x144 framebuffer over a write port with waitrequest.
- Sits between the PPU and the display framebuffer memory.

Parameters:
- FIFO_DEPTH, 8: entries in the write FIFO; power of 2, minimum 2.
- LINE_PX, 160: visible pixels per line; must be a multiple of 4.
- LINES, 144: visible lines per frame.
- FB_BASE, 13'h0000: framebuffer word address of pixel (0,0).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low.
- LCD_EN  in  1  LCDC[7]; low = display off.
- PPU_MODE  in  2  0=H_BLANK, 1=V_BLANK, 2=SCAN, 3=DRAW.
- PX_IN  in  2  pixel colour index.
- PX_valid  in  1  PX_IN valid this cycle.
- BGP  in  8  background palette.
- FB_ADDR  out  13  framebuffer word address.
- FB_WRDATA  out  8  packed pixels; first pixel in [7:6], last in [1:0].
- FB_WR  out  1  write request.
- FB_WAITREQ  in  1  memory stall.
- FRAME_DONE  out  1  one-cycle pulse when a frame is fully written.
- OVERFLOW  out  1  sticky: a packed word was dropped because the FIFO was full.

Behaviour:
- Reset (rst=0, asynchronous) clears all state. Outputs reset to: FB_ADDR=0, FB_WRDATA=0, FB_WR=0, FRAME_DONE=0, OVERFLOW=0. Counters x, y, phase and FIFO pointers are cleared; an in-flight write is abandoned.
- Counters:
  - x: 0..LINE_PX, 8 bits.
  - y: 0..LINES, 8 bits.
  - phase: 0..3; the pack register holds 6 bits of accumulated pixels.
- Pixel accept condition: PX_valid && LCD_EN && x<LINE_PX && y<LINES. On accept: pixel goes into the pack register, x++, phase++.
  - Pixels failing the accept condition are dropped silently.
- Word push: when phase wraps 3->0, push {FB_BASE + y*40 + x[7:2], packed byte} into the FIFO. The push occurs on the cycle after the 4th pixel, giving 1-cycle pack latency.
- Line end: on the cycle where PPU_MODE is H_BLANK and prev_mode was DRAW (a registered edge):
  - If phase!=0, push a partial word with the unfilled low bits = 0.
  - Then x=0, phase=0, y++ (y saturates at LINES).
  - If PX_valid is accepted on the edge cycle, that pixel is packed first, then the flush happens.
- Frame end: on the edge into V_BLANK, y=0, x=0, OVERFLOW clears, and done_pending is set.
  - FRAME_DONE pulses once, the first cycle when done_pending && FIFO empty && !FB_WR; done_pending then clears.
- FIFO full: if a push is needed while full, the word is dropped and OVERFLOW=1. A simultaneous pop frees the slot, so that push is accepted.
- Write FSM, states IDLE and WRITE:
  - IDLE: if the FIFO is non-empty, pop the head into FB_ADDR/FB_WRDATA, set FB_WR=1, go to WRITE.
  - WRITE: hold FB_ADDR, FB_WRDATA and FB_WR while FB_WAITREQ=1.
  - When FB_WAITREQ=0, the write completes. If the FIFO is non-empty, pop the next entry the same cycle (back-to-back, FB_WR stays 1). Otherwise FB_WR=0 and go to IDLE.
  - Sustained throughput is 1 word/cycle with zero wait.
- LCD_EN=0: x, y and phase are held at 0 and done_pending is cleared. The FIFO continues to drain.
- Address arithmetic: y*40 is computed as (y<<5)+(y<<3), truncated to 13 bits. The last word is at 5759.

Optional Feature:
- Macro PPU_FRAME_WRITER_PALETTE_EN.
- Defined: each accepted pixel is replaced by BGP[2*PX_IN+1 : 2*PX_IN] before packing.
- Undefined: the raw PX_IN index is packed and the BGP input is unused.

Test Plan:
1. Reset mid-write (FB_WR=1, FB_WAITREQ=1), then drop rst -> FB_WR=0 immediately (asynchronous), FIFO empty, and no write after release.
2. Line 0, FB_WAITREQ=0, pixels 0,1,2,3,3,2,1,0 -> writes addr 0 = 8'h1B and addr 1 = 8'hE4.
3. DRAW->H_BLANK after 6 pixels of 3 on line 2 -> addr 80 = 8'hFF and addr 81 = 8'hF0; y becomes 3.
4. FB_WAITREQ=1 held for 100 cycles while 40 words arrive (FIFO_DEPTH=8) -> OVERFLOW=1. The first 8 words are written in order after release; OVERFLOW clears on the next V_BLANK entry.
5. Full frame of 144x160 pixels, then V_BLANK -> 5760 writes with the last at addr 5759, and a single FRAME_DONE pulse after the final write completes.
6. Macro defined, BGP=8'hE4 vs 8'h1B, pixels 0,1,2,3 -> 8'h1B vs 8'hE4. Macro undefined -> 8'h1B for both.
